// File: rtl/uart_stim_pkg.sv
// Shared types and constants for the uart_stim transmitter slice.
// Holds the transmit FSM state type, the 16x oversample factor and the
// line levels for the start and stop bits.
package uart_stim_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Clocks per bit = OVERSAMPLE * divisor
    localparam int OVERSAMPLE = 16;

    // Line levels
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Data bits per frame (8N1)
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_stim_fifo.sv
// Generic synchronous FIFO used as the transmit byte queue.
// Latency: a pushed word is visible at pop_dat on the next clock edge.
// Backpressure: full is asserted at 2**AW words; pushes while full are dropped.
//
// Ports:
//   wb_clk_i, wb_rst_ni   clock, asynchronous active-low reset (empties the queue)
//   push, push_dat        write strobe and data
//   pop, pop_dat          read strobe; pop_dat is the current head (show-ahead)
//   full, empty, level    occupancy status, level counts 0 .. 2**AW
module uart_stim_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;
    // level never exceeds 2**AW, so its MSB alone marks full.
    assign full    = level[AW];
    assign empty   = (level == '0);

endmodule

// File: rtl/uart_stim_tx.sv
// 8N1 UART transmitter with a byte queue in front of the serialiser.
// Latency: a byte pushed into an empty queue while idle starts its start bit one clock later.
// Backpressure: tx_ready_o is low while the queue is full and for the first cycle after reset.
//
// Build option UART_STIM_TX_FIFO_EN: when defined the queue is a 2**FIFO_AW-byte
// FIFO (uart_stim_fifo); otherwise it is a single holding register.
//
// Ports:
//   wb_clk_i       single clock, all state on its rising edge
//   wb_rst_ni      asynchronous active-low reset; abandons any frame in flight
//   divisor_i      16x oversample divisor (0 behaves as 1); sampled at each frame start
//   tx_data_i      byte to send, qualified by tx_valid_i
//   tx_valid_i     byte valid; accepted on an edge where tx_ready_o is also high
//   tx_ready_o     queue can accept a byte (registered state only)
//   tx_o           serial line, registered, idle high
//   busy_o         a frame is on the line or bytes are queued
//   tx_done_o      one-cycle pulse at the end of each stop bit
//   fifo_level_o   bytes queued, not counting the one being sent
module uart_stim_tx
    import uart_stim_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [DIV_W-1:0]   divisor_i,
    input  logic [7:0]         tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic               tx_o,
    output logic               busy_o,
    output logic               tx_done_o,
    output logic [FIFO_AW:0]   fifo_level_o
);

    // Wide enough for 16 * (2**DIV_W - 1) - 1 without wrapping.
    localparam int TMR_W = DIV_W + 4;

    // ------------------------------------------------------------------
    // Byte queue
    // ------------------------------------------------------------------
    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic [7:0]       q_dat;
    logic [FIFO_AW:0] q_level;

    // Holds tx_ready_o low until the first edge after reset release.
    logic             rdy_en_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    assign tx_ready_o = rdy_en_q && !q_full;
    assign q_push     = tx_valid_i && tx_ready_o;

`ifdef UART_STIM_TX_FIFO_EN
    uart_stim_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .push      (q_push),
        .push_dat  (tx_data_i),
        .pop       (q_pop),
        .pop_dat   (q_dat),
        .full      (q_full),
        .empty     (q_empty),
        .level     (q_level)
    );
`else
    logic       hold_vld_q;
    logic [7:0] hold_dat_q;

    // Push only happens while empty and pop only while full, so the two
    // never coincide.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            hold_vld_q <= 1'b0;
            hold_dat_q <= 8'h00;
        end else if (q_push) begin
            hold_vld_q <= 1'b1;
            hold_dat_q <= tx_data_i;
        end else if (q_pop) begin
            hold_vld_q <= 1'b0;
        end
    end

    assign q_full  = hold_vld_q;
    assign q_empty = !hold_vld_q;
    assign q_dat   = hold_dat_q;
    assign q_level = {{FIFO_AW{1'b0}}, hold_vld_q};
`endif

    assign fifo_level_o = q_level;

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] bit_len;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_eff;
    logic [2:0]       bit_idx_q;
    logic [7:0]       sh_q;
    logic             bit_end;
    logic             tx_d;
    logic             done_d;

    assign div_eff = (divisor_i == '0) ? DIV_W'(1) : divisor_i;
    assign bit_len = TMR_W'(div_q) * TMR_W'(OVERSAMPLE);
    assign bit_end = (tmr_q == (bit_len - TMR_W'(1)));

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; q_pop marks every frame start, whether from IDLE or
    // straight out of STOP for back-to-back frames.
    always_comb begin
        state_d = state_q;
        q_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_d = ST_START;
                    q_pop   = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_idx_q == 3'(DATA_BITS - 1))) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!q_empty) begin
                        state_d = ST_START;
                        q_pop   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: next line level and done pulse, registered below so tx_o
    // changes on the same edge as the state.
    always_comb begin
        tx_d   = STOP_BIT;
        done_d = (state_q == ST_STOP) && bit_end;
        case (state_d)
            ST_START: tx_d = START_BIT;
            // sh_q[0] is the bit currently on the line; at a bit boundary
            // inside DATA the following bit is sh_q[1].
            ST_DATA:  tx_d = ((state_q == ST_DATA) && bit_end) ? sh_q[1] : sh_q[0];
            default:  tx_d = STOP_BIT;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE) || !q_empty;

    // Datapath: bit timer, shift register, per-frame divisor, output flops.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmr_q     <= '0;
            div_q     <= DIV_W'(1);
            bit_idx_q <= 3'd0;
            sh_q      <= 8'h00;
            tx_o      <= STOP_BIT;
            tx_done_o <= 1'b0;
        end else begin
            tx_o      <= tx_d;
            tx_done_o <= done_d;
            if (q_pop) begin
                // Divisor is latched here so mid-frame changes wait for the next frame.
                div_q     <= div_eff;
                sh_q      <= q_dat;
                tmr_q     <= '0;
                bit_idx_q <= 3'd0;
            end else if (state_q != ST_IDLE) begin
                if (bit_end) begin
                    tmr_q <= '0;
                    if (state_q == ST_DATA) begin
                        sh_q      <= sh_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end else begin
                    tmr_q <= tmr_q + TMR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_stim_tx.sv
module tb_uart_stim_tx;

    localparam int FIFO_AW = 4;
    localparam int DIV_W   = 16;
`ifdef UART_STIM_TX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
`else
    localparam int DEPTH = 1;
`endif

    logic               wb_clk_i = 1'b0;
    logic               wb_rst_ni = 1'b1;
    logic [DIV_W-1:0]   divisor_i = '0;
    logic [7:0]         tx_data_i = 8'h00;
    logic               tx_valid_i = 1'b0;
    logic               tx_ready_o;
    logic               tx_o;
    logic               busy_o;
    logic               tx_done_o;
    logic [FIFO_AW:0]   fifo_level_o;

    uart_stim_tx #(.FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_ni    (wb_rst_ni),
        .divisor_i    (divisor_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .tx_done_o    (tx_done_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int failures = 0;

    // Scenario stimulus
    logic [7:0] tst_bytes[$];
    int         tst_gaps[$];
    int         tst_d0, tst_d1, tst_chg_at;

    // Observations, one entry per falling edge (entry j = state after rising edge j-1)
    logic obs_line[$], obs_done[$], obs_rdy[$], obs_busy[$];
    int   obs_level[$], div_at[$], acc_j[$];

    int err_line, err_done, err_hs, first_bad;

    // Reference: frames are scheduled from accept times; each frame is
    // 10 bits of 16*div clocks, starting one edge after its accept or
    // immediately when the previous frame ends, whichever is later.
    task automatic score_model(input int n);
        int s[$];
        int len[$];
        int prev_end, st, v, eff, e, lvl, ph;
        logic el, ed, eb, er;
        err_line = 0; err_done = 0; err_hs = 0; first_bad = -1; prev_end = 0;
        for (int i = 0; i < acc_j.size(); i++) begin
            st = acc_j[i] + 1;
            if (prev_end > st) st = prev_end;
            v   = (st < n) ? div_at[st] : 1;
            eff = (v == 0) ? 1 : v;
            s.push_back(st);
            len.push_back(10 * 16 * eff);
            prev_end = st + 10 * 16 * eff;
        end
        for (int j = 0; j < n; j++) begin
            e = j - 1; lvl = 0; el = 1'b1; ed = 1'b0; eb = 1'b0;
            for (int i = 0; i < acc_j.size(); i++) begin
                if (acc_j[i] <= e) lvl++;
                if (s[i] <= e) lvl--;
                if (e >= s[i] && e < s[i] + len[i]) begin
                    eb = 1'b1;
                    ph = (e - s[i]) / (len[i] / 10);
                    if (ph == 0)      el = 1'b0;
                    else if (ph == 9) el = 1'b1;
                    else              el = tst_bytes[i][ph-1];
                end
                if (e == s[i] + len[i]) ed = 1'b1;
            end
            if (lvl > 0) eb = 1'b1;
            er = (lvl < DEPTH);
            if (obs_line[j] !== el) begin err_line++; if (first_bad < 0) first_bad = j; end
            if (obs_done[j] !== ed) begin err_done++; if (first_bad < 0) first_bad = j; end
            if (obs_level[j] != lvl || obs_rdy[j] !== er || obs_busy[j] !== eb) begin
                err_hs++; if (first_bad < 0) first_bad = j;
            end
        end
    endtask

    // Drives the queued bytes (with per-byte idle gaps) and records outputs for n cycles.
    task automatic run_scenario(input int n);
        int idx, gap_cnt;
        obs_line.delete(); obs_done.delete(); obs_rdy.delete(); obs_busy.delete();
        obs_level.delete(); div_at.delete(); acc_j.delete();
        divisor_i = DIV_W'(tst_d0);
        idx = 0;
        gap_cnt = (tst_bytes.size() > 0 && tst_gaps.size() > 0) ? tst_gaps[0] : 0;
        for (int j = 0; j < n; j++) begin
            @(negedge wb_clk_i);
            obs_line.push_back(tx_o);
            obs_done.push_back(tx_done_o);
            obs_rdy.push_back(tx_ready_o);
            obs_busy.push_back(busy_o);
            obs_level.push_back(int'(fifo_level_o));
            if (j == tst_chg_at) divisor_i = DIV_W'(tst_d1);
            div_at.push_back(int'(divisor_i));
            if (idx < tst_bytes.size()) begin
                if (gap_cnt > 0) begin
                    tx_valid_i = 1'b0;
                    gap_cnt--;
                end else begin
                    tx_valid_i = 1'b1;
                    tx_data_i  = tst_bytes[idx];
                    if (tx_ready_o) begin
                        acc_j.push_back(j);
                        idx++;
                        gap_cnt = (idx < tst_gaps.size()) ? tst_gaps[idx] : 0;
                    end
                end
            end else begin
                tx_valid_i = 1'b0;
            end
        end
        tx_valid_i = 1'b0;
        score_model(n);
    endtask

    task automatic test_reset();
        tx_valid_i = 1'b0;
        #1 wb_rst_ni = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        checks++; if (tx_o !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx_o); end
        checks++; if (tx_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", tx_ready_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (tx_done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", tx_done_o); end
        checks++; if (fifo_level_o !== '0) begin failures++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
        #2 wb_rst_ni = 1'b1;
        #1;
        checks++; if (tx_ready_o !== 1'b0) begin failures++; $display("FAIL ready_before_edge: got %b want 0", tx_ready_o); end
        @(negedge wb_clk_i);
        checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL ready_after_edge: got %b want 1", tx_ready_o); end
    endtask

    task automatic test_timing();
        int a, k, lowrun, done_at;
        tst_bytes = '{8'h55}; tst_gaps = '{0}; tst_d0 = 26; tst_chg_at = -1; tst_d1 = 26;
        run_scenario(4200);
        checks++; if (acc_j.size() != 1) begin failures++; $display("FAIL timing_accepts: got %0d want 1", acc_j.size()); end
        a = (acc_j.size() > 0) ? acc_j[0] : 0;
        checks++; if (obs_line[a+1] !== 1'b1) begin failures++; $display("FAIL timing_latency_idle: got %b want 1", obs_line[a+1]); end
        lowrun = 0; k = a + 2;
        while (k < obs_line.size() && obs_line[k] === 1'b0) begin lowrun++; k++; end
        checks++; if (lowrun != 416) begin failures++; $display("FAIL timing_start_len: got %0d want 416", lowrun); end
        done_at = -1;
        for (int j = 0; j < obs_done.size(); j++) if (obs_done[j] === 1'b1 && done_at < 0) done_at = j;
        checks++; if (done_at - (a + 2) != 4160) begin failures++; $display("FAIL timing_done_pos: got %0d want 4160", done_at - (a + 2)); end
        checks++; if (err_line != 0) begin failures++; $display("FAIL timing_line: got %0d bad samples (first %0d) want 0", err_line, first_bad); end
        checks++; if (err_done != 0) begin failures++; $display("FAIL timing_done: got %0d bad samples want 0", err_done); end
        checks++; if (err_hs != 0) begin failures++; $display("FAIL timing_status: got %0d bad samples (first %0d) want 0", err_hs, first_bad); end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        tst_bytes = '{8'h41, 8'h42}; tst_gaps = '{0, 0}; tst_d0 = 26; tst_chg_at = -1;
        run_scenario(8400);
        for (int j = 0; j < obs_done.size(); j++) if (obs_done[j] === 1'b1) dq.push_back(j);
        checks++; if (dq.size() != 2) begin failures++; $display("FAIL b2b_done_count: got %0d want 2", dq.size()); end
        if (dq.size() == 2) begin
            checks++; if (dq[1] - dq[0] != 4160) begin failures++; $display("FAIL b2b_done_spacing: got %0d want 4160", dq[1] - dq[0]); end
            checks++; if (obs_line[dq[0]] !== 1'b0) begin failures++; $display("FAIL b2b_no_gap: got %b want 0", obs_line[dq[0]]); end
        end
        checks++; if (err_line != 0) begin failures++; $display("FAIL b2b_line: got %0d bad samples (first %0d) want 0", err_line, first_bad); end
        checks++; if (err_done + err_hs != 0) begin failures++; $display("FAIL b2b_status: got %0d bad samples want 0", err_done + err_hs); end
    endtask

    task automatic test_full_fifo();
        int early;
        tst_bytes.delete(); tst_gaps.delete();
        for (int i = 0; i < 20; i++) begin tst_bytes.push_back(8'($urandom)); tst_gaps.push_back(0); end
        tst_d0 = 1; tst_chg_at = -1;
        run_scenario(3260);
        early = 0;
        foreach (acc_j[i]) if (acc_j[i] < 20) early++;
        checks++; if (early != DEPTH + 1) begin failures++; $display("FAIL full_accepts: got %0d want %0d", early, DEPTH + 1); end
        checks++; if (obs_level[20] != DEPTH) begin failures++; $display("FAIL full_level: got %0d want %0d", obs_level[20], DEPTH); end
        checks++; if (obs_rdy[20] !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", obs_rdy[20]); end
        checks++; if (acc_j.size() != 20) begin failures++; $display("FAIL full_total: got %0d want 20", acc_j.size()); end
        checks++; if (err_line + err_done + err_hs != 0) begin failures++; $display("FAIL full_model: got %0d bad samples (first %0d) want 0", err_line + err_done + err_hs, first_bad); end
    endtask

    task automatic test_div_change();
        int dq[$];
        tst_bytes = '{8'($urandom), 8'($urandom)}; tst_gaps = '{0, 0};
        tst_d0 = 3; tst_chg_at = 100; tst_d1 = 5;
        run_scenario(1320);
        for (int j = 0; j < obs_done.size(); j++) if (obs_done[j] === 1'b1) dq.push_back(j);
        checks++; if (dq.size() != 2) begin failures++; $display("FAIL divchg_done_count: got %0d want 2", dq.size()); end
        if (dq.size() == 2 && acc_j.size() > 0) begin
            checks++; if (dq[0] - (acc_j[0] + 2) != 480) begin failures++; $display("FAIL divchg_frame0: got %0d want 480", dq[0] - (acc_j[0] + 2)); end
            checks++; if (dq[1] - dq[0] != 800) begin failures++; $display("FAIL divchg_frame1: got %0d want 800", dq[1] - dq[0]); end
        end
        checks++; if (err_line + err_done + err_hs != 0) begin failures++; $display("FAIL divchg_model: got %0d bad samples (first %0d) want 0", err_line + err_done + err_hs, first_bad); end
    endtask

    task automatic test_random();
        int nb, n, d, eff, g;
        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(0, 2); eff = (d == 0) ? 1 : d;
            nb = $urandom_range(1, 4);
            tst_bytes.delete(); tst_gaps.delete(); n = 40;
            for (int i = 0; i < nb; i++) begin
                g = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 400);
                tst_bytes.push_back(8'($urandom)); tst_gaps.push_back(g);
                n += g + 1 + 160 * eff;
            end
            tst_d0 = d; tst_chg_at = -1;
            run_scenario(n);
            checks++; if (acc_j.size() != nb) begin failures++; $display("FAIL rand%0d_accepts: got %0d want %0d", it, acc_j.size(), nb); end
            checks++; if (err_line + err_done + err_hs != 0) begin failures++; $display("FAIL rand%0d_model: got %0d bad samples (first %0d) want 0", it, err_line + err_done + err_hs, first_bad); end
        end
    endtask

    task automatic test_reset_mid_frame();
        tst_bytes = '{8'($urandom) & 8'hF7}; tst_gaps = '{0}; tst_d0 = 26; tst_chg_at = -1;
        run_scenario(1800);
        checks++; if (err_line + err_done + err_hs != 0) begin failures++; $display("FAIL midrst_pre_model: got %0d bad samples want 0", err_line + err_done + err_hs); end
        checks++; if (tx_o !== 1'b0) begin failures++; $display("FAIL midrst_bit3_low: got %b want 0", tx_o); end
        wb_rst_ni = 1'b0;
        #1;
        checks++; if (tx_o !== 1'b1) begin failures++; $display("FAIL midrst_tx: got %b want 1", tx_o); end
        checks++; if (tx_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b want 0", tx_ready_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
        checks++; if (fifo_level_o !== '0) begin failures++; $display("FAIL midrst_level: got %0d want 0", fifo_level_o); end
        @(negedge wb_clk_i);
        #2 wb_rst_ni = 1'b1;
        #1;
        checks++; if (tx_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_ready_hold: got %b want 0", tx_ready_o); end
        @(negedge wb_clk_i);
        checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready_rise: got %b want 1", tx_ready_o); end
        tst_bytes.delete(); tst_gaps.delete();
        run_scenario(3000);
        checks++; if (err_done != 0) begin failures++; $display("FAIL midrst_no_done: got %0d pulses want 0", err_done); end
        checks++; if (err_line + err_hs != 0) begin failures++; $display("FAIL midrst_idle: got %0d bad samples (first %0d) want 0", err_line + err_hs, first_bad); end
    endtask

    task automatic test_loopback();
        logic [7:0] rx_q[$];
        logic [7:0] want[$];
        logic [7:0] b;
        int j, mid, dn;
        int bt, n;
        want = '{8'h48, 8'h69, 8'h0A};
        tst_bytes = want; tst_gaps = '{0, 0, 0}; tst_d0 = 26; tst_chg_at = -1;
        n = 3 * 4160 + 40;
        run_scenario(n);
        // Mid-bit sampling receiver
        bt = 16 * 26; j = 1;
        while (j < n) begin
            if (obs_line[j-1] === 1'b1 && obs_line[j] === 1'b0) begin
                mid = j + bt / 2;
                if (mid + 9 * bt < n && obs_line[mid] === 1'b0) begin
                    for (int k = 0; k < 8; k++) b[k] = obs_line[mid + bt * (k + 1)];
                    if (obs_line[mid + 9 * bt] === 1'b1) rx_q.push_back(b);
                    j = mid + 9 * bt;
                end else begin
                    j++;
                end
            end else begin
                j++;
            end
        end
        dn = 0;
        foreach (obs_done[i]) if (obs_done[i] === 1'b1) dn++;
        checks++; if (rx_q.size() != 3) begin failures++; $display("FAIL loop_count: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== want[i]) begin
                failures++;
                $display("FAIL loop_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, want[i]);
            end
        end
        checks++; if (dn != 3) begin failures++; $display("FAIL loop_done_count: got %0d want 3", dn); end
        checks++; if (err_line + err_done + err_hs != 0) begin failures++; $display("FAIL loop_model: got %0d bad samples want 0", err_line + err_done + err_hs); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_back_to_back();
        test_full_fifo();
        test_div_change();
        test_random();
        test_reset_mid_frame();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
